// File: rtl/h_counter.sv
// ---- h_counter : VGA horizontal timing (pixel divider, column count, sync/blank, line-end strobe) ----
// ---- rev 1.0 -------------------------------------------------------------------------------------------
`default_nettype none

module h_counter #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] h_count,
  output logic       enable_v,
  output logic       hsync,
  output logic       h_video_on
);

  localparam int         H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  // 11-bit bounds so a line of exactly 1024 pixels still compares correctly
  localparam logic [10:0] SYNC_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] SYNC_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VIDEO_END  = 11'(H_DISPLAY);

  generate
    if (H_TOTAL > 1024) begin : g_total_check
      $error("h_counter: H_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
      $error("h_counter: CLK_DIV outside 1..16");
    end
  endgenerate

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_count_q, h_count_d;
  logic       in_sync;

  always_comb begin
    div_cnt_d = div_cnt_q + 4'd1;
    h_count_d = h_count_q;
    if (pixel_tick) begin
      div_cnt_d = 4'd0;
      h_count_d = (h_count_q == H_LAST) ? 10'd0 : h_count_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= 4'd0;
      h_count_q <= 10'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_count_q <= h_count_d;
    end
  end

  always_comb begin
    pixel_tick = (div_cnt_q == DIV_LAST);
    h_count    = h_count_q;
    enable_v   = pixel_tick && (h_count_q == H_LAST);
    in_sync    = ({1'b0, h_count_q} >= SYNC_START) && ({1'b0, h_count_q} < SYNC_END);
    hsync      = in_sync ? HSYNC_POL : ~HSYNC_POL;
    h_video_on = ({1'b0, h_count_q} < VIDEO_END);
  end

endmodule

`default_nettype wire

// File: tb/tb_h_counter.sv
// Self-checking bench for h_counter: four parameterisations driven by a shared random reset,
// compared every cycle against an edge-count reference model.
`default_nettype none

module tb_h_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tick, ev, hsy, von;
  logic [9:0] hc0, hc1, hc2, hc3;

  int checks = 0;
  int failures = 0;
  int n = 0;            // edges with rst_n=1 since the last reset edge
  int ev0_pulses = 0;

  always #5 clk = ~clk;

  h_counter u_dut0 (.clk(clk), .rst_n(rst_n), .pixel_tick(tick[0]), .h_count(hc0),
                    .enable_v(ev[0]), .hsync(hsy[0]), .h_video_on(von[0]));
  h_counter #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .pixel_tick(tick[1]), .h_count(hc1),
                    .enable_v(ev[1]), .hsync(hsy[1]), .h_video_on(von[1]));
  h_counter #(.HSYNC_POL(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .pixel_tick(tick[2]), .h_count(hc2),
                    .enable_v(ev[2]), .hsync(hsy[2]), .h_video_on(von[2]));
  h_counter #(.H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .CLK_DIV(3)) u_dut3 (
                    .clk(clk), .rst_n(rst_n), .pixel_tick(tick[3]), .h_count(hc3),
                    .enable_v(ev[3]), .hsync(hsy[3]), .h_video_on(von[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Outputs after n pixel-clock edges: {pixel_tick, enable_v, hsync, h_video_on, h_count}
  function automatic logic [13:0] model(input int edges, input int div, input int hd, input int hf,
                                        input int hs, input int hb, input bit pol);
    int total;
    int h;
    bit t, e, s, v;
    total = hd + hf + hs + hb;
    h = (edges / div) % total;
    t = ((edges + 1) % div) == 0;
    e = t && (h == total - 1);
    s = (h >= hd + hf && h < hd + hf + hs) ? pol : !pol;
    v = h < hd;
    return {t, e, s, v, 10'(h)};
  endfunction

  task automatic cmp_inst(input int i, input logic [13:0] obs, input logic [13:0] exp);
    check($sformatf("i%0d_tick", i),  32'(obs[13]),  32'(exp[13]));
    check($sformatf("i%0d_env", i),   32'(obs[12]),  32'(exp[12]));
    check($sformatf("i%0d_hsync", i), 32'(obs[11]),  32'(exp[11]));
    check($sformatf("i%0d_video", i), 32'(obs[10]),  32'(exp[10]));
    check($sformatf("i%0d_hcount", i), 32'(obs[9:0]), 32'(exp[9:0]));
  endtask

  task automatic compare_all();
    cmp_inst(0, {tick[0], ev[0], hsy[0], von[0], hc0}, model(n, 4, 640, 16, 96, 48, 1'b0));
    cmp_inst(1, {tick[1], ev[1], hsy[1], von[1], hc1}, model(n, 1, 640, 16, 96, 48, 1'b0));
    cmp_inst(2, {tick[2], ev[2], hsy[2], von[2], hc2}, model(n, 4, 640, 16, 96, 48, 1'b1));
    cmp_inst(3, {tick[3], ev[3], hsy[3], von[3], hc3}, model(n, 3, 10, 2, 3, 1, 1'b0));
  endtask

  // Called at a falling edge: drive rst_n, take one rising edge, then check at the next falling edge
  task automatic step(input bit rst_val);
    rst_n = rst_val;
    @(posedge clk);
    if (!rst_n) n = 0;
    else n++;
    @(negedge clk);
    if (ev[0]) ev0_pulses++;
    compare_all();
  endtask

  initial begin
    int waited;
    int gap;
    bit found;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1'b0);

    // two full lines plus a margin
    ev0_pulses = 0;
    for (int i = 0; i < 6500; i++) step(1'b1);
    check("two_line_env_pulses", 32'(ev0_pulses), 32'd2);

    // mid-line reset at column 700
    found = 1'b0;
    for (waited = 0; waited < 4000 && !found; waited++) begin
      if (hc0 == 10'd700) found = 1'b1;
      else step(1'b1);
    end
    check("reach_col_700", 32'(found), 32'd1);
    step(1'b0);
    check("abort_hcount", 32'(hc0), 32'd0);
    check("abort_env", 32'(ev[0]), 32'd0);
    gap = 0;
    found = 1'b0;
    ev0_pulses = 0;
    while (gap < 4000 && !found) begin
      step(1'b1);
      gap++;
      if (ev[0]) found = 1'b1;
    end
    check("env_after_release", 32'(gap), 32'd3199);

    // random reset pulses at random points in the line
    for (int r = 0; r < 10; r++) begin
      int run_len;
      int rst_len;
      run_len = $urandom_range(1, 3500);
      rst_len = $urandom_range(1, 3);
      for (int i = 0; i < run_len; i++) step(1'b1);
      for (int i = 0; i < rst_len; i++) step(1'b0);
    end
    for (int i = 0; i < 3300; i++) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/h_counter.md
# h_counter

Horizontal timing generator for the 640x480 VGA path. Divides the system clock down to a pixel-rate tick and counts pixels across each line. Decodes horizontal sync and active-video from the count. Emits the one-cycle `enable_v` line-end strobe that drives the vertical counter's `enable_v` input, so `v_count` advances exactly once per line.

## Interface

Parameters:
- `H_DISPLAY`, 640, active pixels per line
- `H_FRONT`, 16, front-porch pixels
- `H_SYNC`, 96, sync-pulse pixels
- `H_BACK`, 48, back-porch pixels
- `CLK_DIV`, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); legal range 1..16
- `HSYNC_POL`, 0, active level of `hsync` (0 = active-low)

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `pixel_tick`  output  1  pixel-rate enable, high one clk cycle in every `CLK_DIV`
- `h_count`  output  10  current pixel column, 0..H_TOTAL-1
- `enable_v`  output  1  line-end strobe, one clk cycle wide, to the vertical counter
- `hsync`  output  1  horizontal sync, polarity per `HSYNC_POL`
- `h_video_on`  output  1  high while `h_count` < `H_DISPLAY`

## Operation

- Derived value: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default). It must be ≤1024; elaboration fails otherwise.
- Divider:
  - Internal `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `pixel_tick` = (`div_cnt` == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, `div_cnt` stays 0 and `pixel_tick` is constantly 1 after reset.
- Pixel counter:
  - On an edge where `pixel_tick`=1, `h_count` increments. At H_TOTAL-1 it wraps to 0 instead.
  - Otherwise `h_count` holds.
- `enable_v` = `pixel_tick` AND (`h_count` == H_TOTAL-1), decoded combinationally. It is high exactly during the clk cycle whose closing edge wraps `h_count` to 0, so the vertical counter and `h_count` update on the same edge.
- `hsync` is active (= `HSYNC_POL`) when H_DISPLAY+H_FRONT ≤ `h_count` < H_DISPLAY+H_FRONT+H_SYNC (656..751 by default); otherwise it is inactive.
- `h_video_on` = (`h_count` < H_DISPLAY).
- Every decoded output is a function of registered state only. No input other than `rst_n` affects the outputs.
- Reset:
  - `rst_n`=0 at an edge forces `div_cnt`=0 and `h_count`=0. This overrides any tick or wrap on that same edge.
  - Reset asserted mid-line aborts the line. No `enable_v` is issued for the aborted line.

## Timing

- Outputs during and immediately after reset: `div_cnt`=0, `h_count`=0, `pixel_tick`=0 (CLK_DIV>1), `enable_v`=0, `h_video_on`=1, `hsync`=inactive (1 when HSYNC_POL=0).
- Edges are numbered from the first edge with `rst_n`=1, starting at 1.
- `pixel_tick` is high in the cycle after edges CLK_DIV-1, 2·CLK_DIV-1, and so on.
- `h_count` changes only on edges k·CLK_DIV.
- The line period is H_TOTAL·CLK_DIV clk cycles (3200 by default).
- The first `enable_v` is the cycle after edge 3199. The wrap to `h_count`=0 is at edge 3200; later wraps follow every 3200 edges.
- Latency from `h_count` to `hsync`/`h_video_on`/`enable_v` is zero clk cycles (combinational decode).
- `enable_v` never lasts more than one clk cycle, for any CLK_DIV.

## Test plan

- Reset hold, then release; clk period 10 ns. During reset: `h_count`=0, `enable_v`=0, `hsync`=1, `h_video_on`=1. After release: `pixel_tick` pulses every 4 cycles; `h_count`=1 after edge 4 and 2 after edge 8.
- Run 2 full lines. `enable_v` is high for exactly one cycle at edges 3199→3200 and 6399→6400. `h_count` goes 799→0 at those edges, with no `enable_v` elsewhere.
- Sync/blank decode:
  - `h_video_on` falls when `h_count` 639→640 and rises at 799→0.
  - `hsync` falls at 655→656 and rises at 751→752.
  - The `hsync` low width is 96·4=384 cycles.
- Reset mid-line: assert `rst_n`=0 for one edge at `h_count`=700. Next cycle `h_count`=0 and `div_cnt`=0, with no `enable_v` pulse. The following `enable_v` comes 3200 cycles after release.
- CLK_DIV=1 instance: `pixel_tick` is constant 1. `h_count` increments every edge, `enable_v` pulses every 800 cycles, and each pulse is one cycle wide.
- HSYNC_POL=1 instance: `hsync` is 0 in reset and high only for `h_count` 656..751.
